// File: rtl/fan_bt_cmd_decoder_pkg.sv
// Shared constants, state encoding and command decode for the Bluetooth command decoder.
package fan_bt_cmd_decoder_pkg;

  // ASCII framing and acknowledge bytes
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_K    = 8'h4B;
  localparam logic [7:0] ASC_E    = 8'h45;

  // Command letters (upper case; lower case is folded onto these)
  localparam logic [7:0] ASC_F = 8'h46;
  localparam logic [7:0] ASC_S = 8'h53;
  localparam logic [7:0] ASC_A = 8'h41;
  localparam logic [7:0] ASC_L = 8'h4C;
  localparam logic [7:0] ASC_T = 8'h54;
  localparam logic [7:0] ASC_R = 8'h52;

  // blue_btn_l bit positions, shared with the fan top
  localparam int unsigned BTN_FND   = 0;
  localparam int unsigned BTN_SPEED = 1;
  localparam int unsigned BTN_AUTO  = 2;
  localparam int unsigned BTN_LED   = 3;
  localparam int unsigned BTN_TIMER = 4;
  localparam int unsigned BTN_RESET = 5;
  localparam int unsigned BTN_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CMD,
    ST_WAIT_TERM,
    ST_HOLD,
    ST_ACK
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } cmd_dec_t;

  // Clearing bit 5 folds lower-case letters onto upper case; only the six
  // command letters can match, so other characters stay invalid.
  function automatic cmd_dec_t decode_cmd(input logic [7:0] ch);
    cmd_dec_t   d;
    logic [7:0] up;
    up      = ch & 8'hDF;
    d.valid = 1'b1;
    d.idx   = '0;
    case (up)
      ASC_F:   d.idx = 3'(BTN_FND);
      ASC_S:   d.idx = 3'(BTN_SPEED);
      ASC_A:   d.idx = 3'(BTN_AUTO);
      ASC_L:   d.idx = 3'(BTN_LED);
      ASC_T:   d.idx = 3'(BTN_TIMER);
      ASC_R:   d.idx = 3'(BTN_RESET);
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/fan_bt_cmd_decoder_cycle_timer.sv
// Clearable up-counter with a done flag when the count equals a run-time limit.
module cycle_timer #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles; clear has priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = (r_cnt == i_limit);

endmodule

// File: rtl/fan_bt_cmd_decoder.sv
// Parses "#<cmd><CR|LF>" frames from the Bluetooth UART into stretched
// pseudo-button levels and acknowledges each frame with 'K' or 'E'.
module fan_bt_cmd_decoder
  import fan_bt_cmd_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned PULSE_CYC   = 2_000_000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  output logic [BTN_W-1:0] blue_btn_l,
  output logic [7:0]       err_cnt
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [7:0] r_tx_data;
  logic [7:0] r_err_cnt;

  logic             w_clr;
  logic             w_en;
  logic             w_done;
  logic [CNT_W-1:0] w_limit;
  logic             w_load_idx;
  logic             w_set_ack;
  logic [7:0]       w_ack_byte;
  logic             w_err;
  logic             w_tx_start;
  cmd_dec_t         w_dec;

  // One counter serves both the inter-byte timeout and the hold stretch
  assign w_limit = (r_state == ST_HOLD) ? CNT_W'(PULSE_CYC - 1)
                                        : CNT_W'(TIMEOUT_CYC - 1);
  assign w_en    = (r_state == ST_WAIT_CMD) || (r_state == ST_WAIT_TERM) ||
                   (r_state == ST_HOLD);

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_done  (w_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter control and acknowledge selection
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load_idx  = 1'b0;
    w_set_ack   = 1'b0;
    w_ack_byte  = ASC_E;
    w_err       = 1'b0;
    w_tx_start  = 1'b0;
    w_dec       = decode_cmd(rx_data);
    case (r_state)
      ST_IDLE: begin
        w_clr = 1'b1;
        if (rx_valid && (rx_data == ASC_HASH)) begin
          w_state_nxt = ST_WAIT_CMD;
        end
      end
      ST_WAIT_CMD: begin
        if (rx_valid) begin
          if (w_dec.valid) begin
            w_load_idx  = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = ST_WAIT_TERM;
          end else if (rx_data == ASC_HASH) begin
            w_clr = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_set_ack   = 1'b1;
            w_state_nxt = ST_ACK;
          end
        end else if (w_done) begin
          w_err       = 1'b1;
          w_set_ack   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_WAIT_TERM: begin
        if (rx_valid) begin
          if ((rx_data == ASC_CR) || (rx_data == ASC_LF)) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (rx_data == ASC_HASH) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_WAIT_CMD;
          end else begin
            w_err       = 1'b1;
            w_set_ack   = 1'b1;
            w_state_nxt = ST_ACK;
          end
        end else if (w_done) begin
          w_err       = 1'b1;
          w_set_ack   = 1'b1;
          w_state_nxt = ST_ACK;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          w_set_ack   = 1'b1;
          w_ack_byte  = ASC_K;
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!tx_busy) begin
          w_tx_start  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latched command index, acknowledge byte and saturating error count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx     <= '0;
      r_tx_data <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_load_idx) begin
        r_idx <= w_dec.idx;
      end
      if (w_set_ack) begin
        r_tx_data <= w_ack_byte;
      end
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // Level derives from the async-reset state, so reset drops it immediately
  assign blue_btn_l = (r_state == ST_HOLD) ? (BTN_W'(1) << r_idx) : '0;
  assign tx_start   = w_tx_start;
  assign tx_data    = r_tx_data;
  assign err_cnt    = r_err_cnt;

endmodule
